// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall, flush and forwarding control for the 5-stage
// pipeline, with a timed data-memory handshake and a saturating stall counter.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_d,
  input  logic [4:0]       rs2_d,
  input  logic [4:0]       rs1_e,
  input  logic [4:0]       rs2_e,
  input  logic [4:0]       rd_e,
  input  logic [4:0]       rd_m,
  input  logic [4:0]       rd_w,
  input  logic [1:0]       result_src_e,
  input  logic [1:0]       result_src_m,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_write_m,
  input  logic             pc_src_e,
  input  logic             mem_ready,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_d,
  output logic             flush_e,
  output logic [1:0]       forward_a_e,
  output logic [1:0]       forward_b_e,
  output logic             mem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WW =
    (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WW-1:0] LAST = WW'(MEM_TIMEOUT - 1);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          access_m;
  logic          lw_raw;
  logic          lw_stall;
  logic          at_last;
  logic          freeze;
  logic          m_hit_a, w_hit_a;
  logic          m_hit_b, w_hit_b;

  assign m_hit_a = reg_write_m && rd_m != 5'd0
                && rd_m == rs1_e;
  assign w_hit_a = reg_write_w && rd_w != 5'd0
                && rd_w == rs1_e;
  assign m_hit_b = reg_write_m && rd_m != 5'd0
                && rd_m == rs2_e;
  assign w_hit_b = reg_write_w && rd_w != 5'd0
                && rd_w == rs2_e;

  // M-stage result is younger, so it wins over W
  always_comb begin
    forward_a_e = 2'b00;
    if (m_hit_a)      forward_a_e = 2'b10;
    else if (w_hit_a) forward_a_e = 2'b01;
  end

  always_comb begin
    forward_b_e = 2'b00;
    if (m_hit_b)      forward_b_e = 2'b10;
    else if (w_hit_b) forward_b_e = 2'b01;
  end

  assign access_m = mem_write_m
                 || result_src_m == 2'b01;
  assign lw_raw   = result_src_e == 2'b01
                 && rd_e != 5'd0
                 && (rd_e == rs1_d || rd_e == rs2_d);
  assign lw_stall = lw_raw && !pc_src_e;
  assign at_last  = wait_cnt == LAST;

  always_comb begin
    freeze  = 1'b0;
    mem_req = 1'b0;
    unique case (state)
      RUN: begin
        freeze  = access_m && !mem_ready;
        mem_req = access_m;
      end
      MEM_WAIT: begin
        freeze  = !mem_ready && !at_last;
        mem_req = 1'b1;
      end
      default: begin
        freeze  = 1'b0;
        mem_req = 1'b0;
      end
    endcase
  end

  // a frozen pipeline holds any taken branch until release
  always_comb begin
    stall_f = lw_stall;
    stall_d = lw_stall;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = pc_src_e;
    flush_e = lw_stall || pc_src_e;
    if (freeze) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (access_m && !mem_ready) begin
            state    <= MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (mem_ready) begin
            state <= RUN;
          end else if (at_last) begin
            state       <= RUN;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= RUN;
      endcase
      if ((stall_f || stall_e)
          && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks of pipe_hazard_ctrl
// against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int T = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs1_d = '0, rs2_d = '0;
  logic [4:0] rs1_e = '0, rs2_e = '0;
  logic [4:0] rd_e = '0, rd_m = '0, rd_w = '0;
  logic [1:0] result_src_e = '0;
  logic [1:0] result_src_m = '0;
  logic       reg_write_m = 1'b0;
  logic       reg_write_w = 1'b0;
  logic       mem_write_m = 1'b0;
  logic       pc_src_e = 1'b0;
  logic       mem_ready = 1'b0;

  logic        stall_f, stall_d, stall_e, stall_m;
  logic        flush_d, flush_e, mem_req, mem_timeout;
  logic [1:0]  forward_a_e, forward_b_e;
  logic [15:0] stall_count;

  logic        x_sf, x_sd, x_se, x_sm;
  logic        x_fd, x_fe, x_req, x_to;
  logic [1:0]  x_fa, x_fb;
  logic [3:0]  x_cnt;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .result_src_e(result_src_e),
    .result_src_m(result_src_m),
    .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w),
    .mem_write_m(mem_write_m),
    .pc_src_e(pc_src_e),
    .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_d(stall_d),
    .stall_e(stall_e), .stall_m(stall_m),
    .flush_d(flush_d), .flush_e(flush_e),
    .forward_a_e(forward_a_e),
    .forward_b_e(forward_b_e),
    .mem_req(mem_req),
    .mem_timeout(mem_timeout),
    .stall_count(stall_count)
  );

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .rs1_d(rs1_d), .rs2_d(rs2_d),
    .rs1_e(rs1_e), .rs2_e(rs2_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w),
    .result_src_e(result_src_e),
    .result_src_m(result_src_m),
    .reg_write_m(reg_write_m),
    .reg_write_w(reg_write_w),
    .mem_write_m(mem_write_m),
    .pc_src_e(pc_src_e),
    .mem_ready(mem_ready),
    .stall_f(x_sf), .stall_d(x_sd),
    .stall_e(x_se), .stall_m(x_sm),
    .flush_d(x_fd), .flush_e(x_fe),
    .forward_a_e(x_fa),
    .forward_b_e(x_fb),
    .mem_req(x_req),
    .mem_timeout(x_to),
    .stall_count(x_cnt)
  );

  always #5 clk = ~clk;

  // reference model: an open access and how many frozen cycles it has used
  bit m_busy;
  int m_used;
  bit m_to;
  int m_cnt16;
  int m_cnt4;
  int n_chk;
  int n_fail;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic int fwd(input logic [4:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2;
    if (reg_write_w && rd_w != 0 && rd_w == rs) return 1;
    return 0;
  endfunction

  function automatic bit acc();
    return mem_write_m || result_src_m == 2'b01;
  endfunction

  function automatic bit lw();
    return result_src_e == 2'b01 && rd_e != 0
        && (rd_e == rs1_d || rd_e == rs2_d)
        && !pc_src_e;
  endfunction

  function automatic bit frz();
    if (mem_ready) return 0;
    if (m_busy) return m_used < T;
    return acc();
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_used  = 0;
    m_to    = 0;
    m_cnt16 = 0;
    m_cnt4  = 0;
  endtask

  task automatic check_all();
    bit f, l;
    f = frz();
    l = lw();
    chk("fwd_a", forward_a_e, fwd(rs1_e));
    chk("fwd_b", forward_b_e, fwd(rs2_e));
    chk("stall_f", stall_f, f | l);
    chk("stall_d", stall_d, f | l);
    chk("stall_e", stall_e, f);
    chk("stall_m", stall_m, f);
    chk("flush_d", flush_d, !f & pc_src_e);
    chk("flush_e", flush_e, !f & (l | pc_src_e));
    chk("mem_req", mem_req, m_busy | acc());
    chk("mem_timeout", mem_timeout, m_to);
    chk("count16", stall_count, m_cnt16);
    chk("count4", x_cnt, m_cnt4);
  endtask

  task automatic model_tick();
    bit stall_any;
    stall_any = frz() | lw();
    if (m_busy) begin
      if (mem_ready) begin
        m_busy = 0;
      end else if (m_used == T) begin
        m_busy = 0;
        m_to   = 1;
      end else begin
        m_used++;
      end
    end else if (acc() && !mem_ready) begin
      m_busy = 1;
      m_used = 1;
    end
    if (stall_any) begin
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic clear_in();
    rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0;
    rd_e = 0; rd_m = 0; rd_w = 0;
    result_src_e = 0; result_src_m = 0;
    reg_write_m = 0; reg_write_w = 0;
    mem_write_m = 0; pc_src_e = 0;
    mem_ready = 0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    clear_in();

    // reset state
    #3;
    check_all();
    #4 rst = 1'b1;

    // forwarding, M over W, then W when rd_m is x0
    rd_m = 5; reg_write_m = 1;
    rd_w = 5; reg_write_w = 1;
    rs1_e = 5; rs2_e = 0;
    step();
    rd_m = 0;
    step();
    clear_in();

    // load-use, without then with a taken branch
    result_src_e = 2'b01; rd_e = 3; rs2_d = 3;
    step();
    pc_src_e = 1;
    step();
    clear_in();
    step();

    // memory wait: three not-ready cycles then ready
    mem_write_m = 1;
    repeat (3) step();
    mem_ready = 1;
    step();
    clear_in();
    step();

    // timeout: ready never comes
    result_src_m = 2'b01;
    repeat (T + 1) step();
    clear_in();
    mem_ready = 1;
    repeat (3) step();

    // asynchronous reset on wait cycle 2
    clear_in();
    mem_write_m = 1;
    repeat (2) step();
    mem_write_m = 0;
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_count", stall_count, 0);
    chk("rst_timeout", mem_timeout, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_stall", stall_f, 0);
    #1 rst = 1'b1;
    step();

    // saturation of the narrow counter
    result_src_e = 2'b01; rd_e = 7; rs1_d = 7;
    repeat (20) step();
    chk("sat4", x_cnt, 15);
    clear_in();
    step();

    // random traffic on a small register window
    for (int i = 0; i < 400; i++) begin
      rs1_d = 5'($urandom_range(0, 3));
      rs2_d = 5'($urandom_range(0, 3));
      rs1_e = 5'($urandom_range(0, 3));
      rs2_e = 5'($urandom_range(0, 3));
      rd_e  = 5'($urandom_range(0, 3));
      rd_m  = 5'($urandom_range(0, 3));
      rd_w  = 5'($urandom_range(0, 3));
      result_src_e = 2'($urandom_range(0, 3));
      result_src_m = ($urandom_range(0, 3) == 0)
                   ? 2'b01 : 2'b00;
      reg_write_m = 1'($urandom_range(0, 1));
      reg_write_w = 1'($urandom_range(0, 1));
      mem_write_m = ($urandom_range(0, 5) == 0);
      pc_src_e    = ($urandom_range(0, 4) == 0);
      mem_ready   = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard and stall controller for the 5-stage pipeline. It produces per-stage stall and flush controls for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the EX-stage forwarding selects. It sequences a multi-cycle data-memory access in the M stage through a req/ready handshake with a timeout, and it keeps a saturating stall-cycle counter.

Parameters:
MEM_TIMEOUT, 16, number of cycles spent in MEM_WAIT before the access is abandoned
CNT_W, 16, width of stall_count

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  asynchronous, active-low reset
rs1_d  in  5  D-stage source register 1
rs2_d  in  5  D-stage source register 2
rs1_e  in  5  E-stage source register 1
rs2_e  in  5  E-stage source register 2
rd_e  in  5  E-stage destination register
rd_m  in  5  M-stage destination register
rd_w  in  5  W-stage destination register
result_src_e  in  2  E-stage result select; 2'b01 means load
result_src_m  in  2  M-stage result select; 2'b01 means load
reg_write_m  in  1  M-stage register write
reg_write_w  in  1  W-stage register write
mem_write_m  in  1  M-stage store
pc_src_e  in  1  branch or jump taken in E
mem_ready  in  1  data memory completes the access this cycle
stall_f  out  1  hold PC
stall_d  out  1  hold IF/ID
stall_e  out  1  hold ID/EX
stall_m  out  1  hold EX/MEM and MEM/WB
flush_d  out  1  clear IF/ID
flush_e  out  1  clear ID/EX
forward_a_e  out  2  operand A select: 00 regfile, 01 W result, 10 M ALU result
forward_b_e  out  2  operand B select, same encoding
mem_req  out  1  data memory request
mem_timeout  out  1  sticky access-timeout flag
stall_count  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (rst=0, asynchronous): state=RUN, wait_cnt=0, mem_timeout=0, stall_count=0. The combinational outputs then follow the RUN equations below.
- Forwarding (combinational), forward_a_e:
  - 10 if reg_write_m, rd_m!=0 and rd_m==rs1_e.
  - Otherwise 01 if reg_write_w, rd_w!=0 and rd_w==rs1_e.
  - Otherwise 00.
  - M has priority over W. forward_b_e uses rs2_e the same way.
- access_m = mem_write_m | (result_src_m==2'b01).
- lw_raw = (result_src_e==2'b01) & rd_e!=0 & (rd_e==rs1_d | rd_e==rs2_d).
- lw_stall = lw_raw & ~pc_src_e. A taken branch squashes the dependent instruction, so no stall is needed.
- FSM, two states:
  - RUN: if access_m & ~mem_ready, go to MEM_WAIT and set wait_cnt=0. Otherwise stay in RUN.
  - MEM_WAIT:
    - If mem_ready, go to RUN.
    - Else if wait_cnt==MEM_TIMEOUT-1, go to RUN and set mem_timeout=1 (sticky until reset).
    - Else increment wait_cnt.
- mem_req = (RUN & access_m) | MEM_WAIT.
- freeze = (RUN & access_m & ~mem_ready) | (MEM_WAIT & ~mem_ready & wait_cnt!=MEM_TIMEOUT-1).
  - It deasserts combinationally in the ready or timeout cycle, so the pipeline advances that cycle.
- Output priority:
  - If freeze: stall_f=stall_d=stall_e=stall_m=1 and flush_d=flush_e=0. A pending pc_src_e is held and takes effect after release.
  - Else: stall_f=stall_d=lw_stall, stall_e=stall_m=0, flush_d=pc_src_e, flush_e=lw_stall|pc_src_e.
- stall_count increments on every edge where stall_f|stall_e=1 and saturates at all ones (no wrap).
- A reset during MEM_WAIT aborts the access: mem_req is 0 after reset unless access_m is asserted.
- A timeout abandons the access. The load result is undefined; the pipeline continues.

Test Plan:
- Forwarding: rd_m=5 with reg_write_m=1, rd_w=5 with reg_write_w=1, rs1_e=5, rs2_e=0 -> forward_a_e=10, forward_b_e=00. With rd_m=0 -> forward_a_e=01.
- Load-use: result_src_e=01, rd_e=3, rs2_d=3, pc_src_e=0 -> stall_f=stall_d=1, flush_e=1 for one cycle; stall_count goes 0→1. Repeat with pc_src_e=1 -> stall_f=0, flush_d=flush_e=1.
- Memory wait: access_m=1, mem_ready low for 3 cycles then high -> all stalls=1 and mem_req=1 for 3 cycles, released in the ready cycle; state back to RUN; stall_count=3.
- Timeout: access_m=1, mem_ready held 0, MEM_TIMEOUT=16 -> freeze for 16 cycles, then mem_timeout=1 and stays 1; stalls drop in the 17th cycle.
- Reset mid-wait: rst pulsed low on wait cycle 2 -> immediately state=RUN, stall_count=0, mem_timeout=0.
- Saturation: CNT_W=4, 20 consecutive stall cycles -> stall_count=15 and holds.
